// File: rtl/uart_cmd_ctrl.sv
// UART frame controller: SYNC, ADDR, LEN, payload, CHK -> checked register-write burst.
// Optional inter-byte timeout compiled in with `define UART_CMD_TIMEOUT_EN.
module uart_cmd_ctrl #(
  parameter int          CLOCK_RATE     = 100_000_000,
  parameter int          TIMEOUT_CYCLES = 1_000_000,
  parameter int          MAX_LEN        = 16,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_ready,
  input  logic [7:0] rx_data,
  input  logic       wr_ready,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       frame_done,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       busy
);

  localparam int         IDX_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_LEN, S_DATA, S_CHK, S_FLUSH} state_e;

  state_e                    state_q;
  logic                      rx_ready_q;
  logic [7:0]                base_q, chk_q;
  logic [IDX_W-1:0]          len_m1_q, idx_q;
  logic                      wr_en_q, frame_done_q, frame_err_q;
  logic [7:0]                wr_addr_q, wr_data_q;
  logic [1:0]                err_code_q;
  logic [MAX_LEN-1:0][7:0]   buf_q;

  logic                      accept;
  logic                      framing;
  logic                      tmo_hit;
  logic [IDX_W-1:0]          idx_inc;

  // Rising edge of rx_ready marks one byte, however long the level is held.
  assign accept  = rx_ready & ~rx_ready_q;
  assign framing = (state_q == S_ADDR) || (state_q == S_LEN) ||
                   (state_q == S_DATA) || (state_q == S_CHK);
  assign idx_inc = idx_q + 1'b1;

`ifdef UART_CMD_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TMO_W-1:0] tmo_q;

  // A byte arriving in the expiry cycle wins over the timeout.
  assign tmo_hit = framing && !accept && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          tmo_q <= '0;
    else if (!framing || accept || tmo_hit) tmo_q <= '0;
    else                                 tmo_q <= tmo_q + 1'b1;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // Payload store; contents are don't-care until written by the current frame.
  always_ff @(posedge clk) begin
    if (state_q == S_DATA && accept) buf_q[idx_q] <= rx_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      rx_ready_q   <= 1'b0;
      base_q       <= '0;
      chk_q        <= '0;
      len_m1_q     <= '0;
      idx_q        <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      err_code_q   <= '0;
    end else begin
      rx_ready_q   <= rx_ready;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept && rx_data == SYNC_BYTE) state_q <= S_ADDR;
        end
        S_ADDR: begin
          if (accept) begin
            base_q  <= rx_data;
            chk_q   <= rx_data;
            state_q <= S_LEN;
          end
        end
        S_LEN: begin
          if (accept) begin
            if (rx_data == 8'd0 || rx_data > MAX_LEN_B) begin
              frame_err_q <= 1'b1;
              err_code_q  <= 2'd1;
              state_q     <= S_IDLE;
            end else begin
              len_m1_q <= IDX_W'(rx_data - 8'd1);
              chk_q    <= chk_q ^ rx_data;
              idx_q    <= '0;
              state_q  <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (accept) begin
            chk_q <= chk_q ^ rx_data;
            if (idx_q == len_m1_q) state_q <= S_CHK;
            else                   idx_q   <= idx_inc;
          end
        end
        S_CHK: begin
          if (accept) begin
            if (rx_data == chk_q) begin
              idx_q     <= '0;
              wr_en_q   <= 1'b1;
              wr_addr_q <= base_q;
              wr_data_q <= buf_q[0];
              state_q   <= S_FLUSH;
            end else begin
              frame_err_q <= 1'b1;
              err_code_q  <= 2'd2;
              state_q     <= S_IDLE;
            end
          end
        end
        S_FLUSH: begin
          // Bytes during the burst are dropped and flagged; the burst carries on.
          if (accept) begin
            frame_err_q <= 1'b1;
            err_code_q  <= 2'd0;
          end
          if (wr_en_q && wr_ready) begin
            if (idx_q == len_m1_q) begin
              wr_en_q      <= 1'b0;
              frame_done_q <= 1'b1;
              state_q      <= S_IDLE;
            end else begin
              idx_q     <= idx_inc;
              wr_addr_q <= base_q + 8'(idx_inc);
              wr_data_q <= buf_q[idx_inc];
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
      if (tmo_hit) begin
        frame_err_q <= 1'b1;
        err_code_q  <= 2'd3;
        state_q     <= S_IDLE;
      end
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;
  assign err_code   = err_code_q;
  assign busy       = (state_q != S_IDLE);

endmodule
